// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg : shared sizes and FSM encoding for the 16-way round-robin arbiter
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package arb_pkg;

    localparam int N_REQ = 16;
    localparam int IDX_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage : arb_pkg

`default_nettype wire

// File: rtl/pencode16.sv
// -----------------------------------------------------------------------------
// pencode16 : combinational 16->4 priority encoder, lowest set bit wins
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module pencode16
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] in_vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan from the top down so the lowest set bit is the last to write idx.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (in_vec[i]) begin
                idx = IDX_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule : pencode16

`default_nettype wire

// File: rtl/rr_arbiter16.sv
// -----------------------------------------------------------------------------
// rr_arbiter16 : round-robin arbiter for 16 requesters with hold timeout
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module rr_arbiter16
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             owner_release,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             timeout
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    arb_state_t       state;
    logic [IDX_W-1:0] ptr;
    logic [7:0]       hold_cnt;

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [IDX_W-1:0]   enc_idx;
    logic               enc_any;
    logic [IDX_W-1:0]   winner;
    logic               owner_done;

    // Rotating right by ptr puts requester ptr at bit 0, so the lowest-set-bit
    // encoder searches ascending from ptr with wrap.
    assign req_dbl = {req, req};
    assign req_rot = req_dbl[ptr +: N_REQ];
    assign winner  = enc_idx + ptr;

    pencode16 u_pencode (
        .in_vec (req_rot),
        .idx    (enc_idx),
        .any    (enc_any)
    );

    assign owner_done = owner_release || !req[grant_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
            ptr         <= '0;
            hold_cnt    <= '0;
        end else begin
            timeout <= 1'b0;
            if (state == IDLE) begin
                if (enc_any) begin
                    state       <= BUSY;
                    grant       <= N_REQ'(1) << winner;
                    grant_idx   <= winner;
                    grant_valid <= 1'b1;
                    hold_cnt    <= '0;
                    ptr         <= winner + IDX_W'(1);
                end
            end else begin
                if (owner_done) begin
                    state       <= IDLE;
                    grant       <= '0;
                    grant_valid <= 1'b0;
                end else if (hold_cnt == HOLD_LAST) begin
                    // Forced revoke; a release or drop in this cycle wins above.
                    state       <= IDLE;
                    grant       <= '0;
                    grant_valid <= 1'b0;
                    timeout     <= 1'b1;
                end else begin
                    hold_cnt <= hold_cnt + 8'd1;
                end
            end
        end
    end

endmodule : rr_arbiter16

`default_nettype wire

// File: tb/tb_rr_arbiter16.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter16 : directed self-checking bench for rr_arbiter16
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_rr_arbiter16;

    logic        clk;
    logic        rst;
    logic [15:0] req;
    logic        owner_release;
    logic [15:0] grant;
    logic [3:0]  grant_idx;
    logic        grant_valid;
    logic        timeout;

    int checks   = 0;
    int failures = 0;

    rr_arbiter16 #(.MAX_HOLD(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .owner_release (owner_release),
        .grant         (grant),
        .grant_idx     (grant_idx),
        .grant_valid   (grant_valid),
        .timeout       (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_grant(input string tag, input int idx);
        logic [15:0] onehot;
        onehot = 16'h0001 << idx;
        check_value({tag, "_grant"}, {16'h0, grant}, {16'h0, onehot});
        check_value({tag, "_idx"}, {28'h0, grant_idx}, 32'(idx));
        check_value({tag, "_valid"}, {31'h0, grant_valid}, 32'd1);
    endtask

    task automatic check_idle(input string tag, input logic exp_to);
        check_value({tag, "_grant0"}, {16'h0, grant}, 32'h0);
        check_value({tag, "_valid0"}, {31'h0, grant_valid}, 32'd0);
        check_value({tag, "_timeout"}, {31'h0, timeout}, {31'h0, exp_to});
    endtask

    initial begin
        rst           = 1'b1;
        req           = 16'h0;
        owner_release = 1'b0;
        #3;
        check_value("rst_grant", {16'h0, grant}, 32'h0);
        check_value("rst_idx", {28'h0, grant_idx}, 32'h0);
        check_value("rst_valid", {31'h0, grant_valid}, 32'h0);
        check_value("rst_timeout", {31'h0, timeout}, 32'h0);
        tick();
        tick();
        rst = 1'b0;

        // Single request, then release; ptr must land on 4.
        req = 16'h0008;
        tick();
        check_grant("single", 3);
        owner_release = 1'b1;
        tick();
        check_idle("single_rel", 1'b0);
        owner_release = 1'b0;
        req = 16'h0028;
        tick();
        check_grant("ptr4", 5);

        // Asynchronous reset while BUSY clears outputs without a clock edge.
        #1 rst = 1'b1;
        #1;
        check_value("arst_grant", {16'h0, grant}, 32'h0);
        check_value("arst_idx", {28'h0, grant_idx}, 32'h0);
        check_value("arst_valid", {31'h0, grant_valid}, 32'h0);
        #1 rst = 1'b0;

        // Full round robin from ptr=0 with one-cycle ownership.
        req = 16'hFFFF;
        for (int k = 0; k < 17; k++) begin
            tick();
            check_grant($sformatf("rr%0d", k), k % 16);
            owner_release = 1'b1;
            tick();
            check_idle($sformatf("rr_gap%0d", k), 1'b0);
            owner_release = 1'b0;
        end
        req = 16'h0;
        tick();

        // Wrap: after grant 14, ptr=15 so bit 0 beats bit 14.
        req = 16'h4000;
        tick();
        check_grant("pre_wrap", 14);
        owner_release = 1'b1;
        tick();
        owner_release = 1'b0;
        req = 16'h4001;
        tick();
        check_grant("wrap", 0);
        owner_release = 1'b1;
        tick();
        owner_release = 1'b0;

        // Timeout: eight cycles of grant, then a pulse as the grant drops.
        req = 16'h0020;
        tick();
        for (int c = 1; c <= 8; c++) begin
            check_grant($sformatf("hold%0d", c), 5);
            check_value($sformatf("hold%0d_to", c), {31'h0, timeout}, 32'd0);
            tick();
        end
        check_idle("to_drop", 1'b1);
        tick();
        check_grant("regrant", 5);
        check_value("regrant_to", {31'h0, timeout}, 32'd0);

        // Release on the eighth cycle suppresses the timeout pulse.
        for (int c = 1; c < 8; c++) tick();
        check_grant("hold8_rel", 5);
        owner_release = 1'b1;
        tick();
        check_idle("rel_at_to", 1'b0);
        owner_release = 1'b0;

        // Owner drop mid-grant; another request must wait for an idle cycle.
        tick();
        check_grant("drop_pre", 5);
        tick();
        req = 16'h0001;
        tick();
        check_idle("drop", 1'b0);
        tick();
        check_grant("after_drop", 0);

        // Release while idle is ignored.
        owner_release = 1'b1;
        req = 16'h0;
        tick();
        tick();
        check_idle("idle_rel", 1'b0);
        owner_release = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_rr_arbiter16

`default_nettype wire
